audio_steer_ctrl: RTL and testbench

//  Parametrised successor to the two-mic steering controller. Pairs left/right integrated

---
 rtl/audio_steer_ctrl_pkg.sv | 19 +
 rtl/audio_steer_ctrl_if.sv | 27 ++
 rtl/audio_steer_ctrl_pair_capture.sv | 96 +++++++++
 rtl/audio_steer_ctrl.sv | 165 ++++++++++++++++
 tb/tb_audio_steer_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_steer_ctrl_pkg.sv
// Shared definitions for the audio steering controller: FSM state encoding and
// default tuning constants for the deadband and the step scaling.
package audio_steer_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAccum,
        StDecide,
        StIssue
    } state_e;

    localparam int unsigned DefThresh    = 8000;
    localparam int unsigned DefHyst      = 1000;
    localparam int unsigned DefStepUnit  = 16;
    localparam int unsigned DefStepShift = 5;
    localparam int unsigned DefTimeout   = 1000000;

endpackage

// File: rtl/audio_steer_ctrl_if.sv
// Sample inputs from the mic integrators and the step-command handshake to the
// motor driver. The master drives samples and ack; the controller is the slave.
interface audio_steer_ctrl_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned VAL_W = 8
);
    logic [W-1:0]     int_l;
    logic             int_l_valid;
    logic [W-1:0]     int_r;
    logic             int_r_valid;
    logic             motor_ack;
    logic             cmd_valid;
    logic             dir;
    logic [VAL_W-1:0] val;
    logic             err_timeout;
    logic             sample_drop;

    modport master (
        output int_l, int_l_valid, int_r, int_r_valid, motor_ack,
        input  cmd_valid, dir, val, err_timeout, sample_drop
    );

    modport slave (
        input  int_l, int_l_valid, int_r, int_r_valid, motor_ack,
        output cmd_valid, dir, val, err_timeout, sample_drop
    );
endinterface

// File: rtl/audio_steer_ctrl_pair_capture.sv
// Pairs left/right samples arriving on independent strobes. A lone sample is
// held (newest same-side sample wins) until its partner arrives or the wait
// timer expires, in which case it is discarded with a one-cycle err_timeout.
module audio_steer_ctrl_pair_capture #(
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         accept_i,
    input  logic         l_valid_i,
    input  logic [W-1:0] l_i,
    input  logic         r_valid_i,
    input  logic [W-1:0] r_i,
    output logic         pair_valid_o,
    output logic [W-1:0] pair_l_o,
    output logic [W-1:0] pair_r_o,
    output logic         holding_o,
    output logic         err_timeout_o
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic          held_l_q, held_l_d, held_r_q, held_r_d;
    logic [W-1:0]  lat_l_q, lat_l_d, lat_r_q, lat_r_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          lv, rv;

    assign lv = l_valid_i & accept_i;
    assign rv = r_valid_i & accept_i;

    // A pair completes on the strobe that meets a held partner (or both at once).
    assign pair_valid_o = (lv & rv) | (held_l_q & rv) | (held_r_q & lv);
    assign pair_l_o     = lv ? l_i : lat_l_q;
    assign pair_r_o     = rv ? r_i : lat_r_q;
    assign holding_o    = held_l_d | held_r_d;
    assign err_timeout_o = err_q;

    // Latch/overwrite held samples and run the partner wait timer.
    always_comb begin
        held_l_d = held_l_q;
        held_r_d = held_r_q;
        lat_l_d  = lat_l_q;
        lat_r_d  = lat_r_q;
        timer_d  = timer_q;
        err_d    = 1'b0;
        if (pair_valid_o) begin
            held_l_d = 1'b0;
            held_r_d = 1'b0;
            timer_d  = '0;
        end else if (held_l_q | held_r_q) begin
            // Only same-side strobes reach here; they refresh data, not the timer.
            if (lv) lat_l_d = l_i;
            if (rv) lat_r_d = r_i;
            if (timer_q == TW'(TIMEOUT - 1)) begin
                held_l_d = 1'b0;
                held_r_d = 1'b0;
                timer_d  = '0;
                err_d    = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            if (lv) begin
                lat_l_d  = l_i;
                held_l_d = 1'b1;
                timer_d  = '0;
            end
            if (rv) begin
                lat_r_d  = r_i;
                held_r_d = 1'b1;
                timer_d  = '0;
            end
        end
    end

    // Capture state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_l_q <= 1'b0;
            held_r_q <= 1'b0;
            lat_l_q  <= '0;
            lat_r_q  <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            held_l_q <= held_l_d;
            held_r_q <= held_r_d;
            lat_l_q  <= lat_l_d;
            lat_r_q  <= lat_r_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/audio_steer_ctrl.sv
// Two-mic steering controller: accumulates 2^AVG_LOG2 sample pairs, compares
// the averages against a hysteretic deadband and issues a saturated step
// command to the motor driver over a valid/ack handshake.
module audio_steer_ctrl
    import audio_steer_ctrl_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned VAL_W      = 8,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned THRESH     = DefThresh,
    parameter int unsigned HYST       = DefHyst,
    parameter int unsigned STEP_UNIT  = DefStepUnit,
    parameter int unsigned STEP_SHIFT = DefStepShift,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input logic               clk_i,
    input logic               rst_i,
    audio_steer_ctrl_if.slave bus
);
    localparam int unsigned W1    = W + 1;
    localparam int unsigned SW    = W + AVG_LOG2;
    localparam int unsigned CW    = AVG_LOG2 + 1;
    localparam int unsigned ProdW = W1 + $clog2(STEP_UNIT + 1) + VAL_W;
    localparam logic [W1-1:0]    ThrLo  = W1'(THRESH - HYST);
    localparam logic [W1-1:0]    ThrHi  = W1'(THRESH);
    localparam logic [CW-1:0]    NPairs = CW'(1 << AVG_LOG2);
    localparam logic [VAL_W-1:0] ValMax = '1;

    state_e           state_q, state_d, rest_state;
    logic [SW-1:0]    sum_l_q, sum_l_d, sum_r_q, sum_r_d;
    logic [CW-1:0]    count_q, count_d;
    logic [W-1:0]     avg_l_q, avg_l_d, avg_r_q, avg_r_d;
    logic             engaged_q, engaged_d;
    logic             dir_q, dir_d;
    logic [VAL_W-1:0] val_q, val_d;
    logic             drop_q, drop_d;

    logic             pair_valid, holding, accept, window_full;
    logic [W-1:0]     pair_l, pair_r;
    logic signed [W1-1:0] diff;
    logic [W1-1:0]    abs_diff, thr, mag;
    logic [ProdW-1:0] steps_raw;
    logic [VAL_W-1:0] steps;
    logic             over;

    // Samples are refused while deciding/issuing, and in the ACCUM cycle that
    // closes a full window (its pair would otherwise fall between windows).
    assign window_full = (count_q == NPairs);
    assign accept = (state_q == StIdle) || (state_q == StWait) ||
                    ((state_q == StAccum) && !window_full);
    assign drop_d = !accept && (bus.int_l_valid || bus.int_r_valid);
    assign rest_state = holding ? StWait : StIdle;

    audio_steer_ctrl_pair_capture #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) u_capture (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .accept_i      (accept),
        .l_valid_i     (bus.int_l_valid),
        .l_i           (bus.int_l),
        .r_valid_i     (bus.int_r_valid),
        .r_i           (bus.int_r),
        .pair_valid_o  (pair_valid),
        .pair_l_o      (pair_l),
        .pair_r_o      (pair_r),
        .holding_o     (holding),
        .err_timeout_o (bus.err_timeout)
    );

    // Decision datapath: signed difference, hysteretic threshold, saturated steps.
    always_comb begin
        diff      = $signed({1'b0, avg_r_q}) - $signed({1'b0, avg_l_q});
        abs_diff  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        thr       = engaged_q ? ThrLo : ThrHi;
        over      = abs_diff > thr;
        mag       = abs_diff - thr;
        steps_raw = ProdW'(mag >> STEP_SHIFT) * ProdW'(STEP_UNIT);
        steps     = (steps_raw > ProdW'(ValMax)) ? ValMax : steps_raw[VAL_W-1:0];
    end

    // Next-state: accumulate pairs, close the window, decide and hold the command.
    always_comb begin
        state_d   = state_q;
        sum_l_d   = sum_l_q;
        sum_r_d   = sum_r_q;
        count_d   = count_q;
        avg_l_d   = avg_l_q;
        avg_r_d   = avg_r_q;
        engaged_d = engaged_q;
        dir_d     = dir_q;
        val_d     = val_q;
        if (pair_valid) begin
            sum_l_d = sum_l_q + SW'(pair_l);
            sum_r_d = sum_r_q + SW'(pair_r);
            count_d = count_q + CW'(1);
        end
        unique case (state_q)
            StIdle, StWait: begin
                state_d = pair_valid ? StAccum : rest_state;
            end
            StAccum: begin
                if (window_full) begin
                    avg_l_d = W'(sum_l_q >> AVG_LOG2);
                    avg_r_d = W'(sum_r_q >> AVG_LOG2);
                    sum_l_d = '0;
                    sum_r_d = '0;
                    count_d = '0;
                    state_d = StDecide;
                end else begin
                    state_d = pair_valid ? StAccum : rest_state;
                end
            end
            StDecide: begin
                if (abs_diff <= ThrLo) engaged_d = 1'b0;
                if (over && (steps != '0)) begin
                    dir_d     = ~diff[W];
                    val_d     = steps;
                    engaged_d = 1'b1;
                    state_d   = StIssue;
                end else begin
                    state_d = rest_state;
                end
            end
            StIssue: begin
                if (bus.motor_ack) state_d = rest_state;
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            sum_l_q   <= '0;
            sum_r_q   <= '0;
            count_q   <= '0;
            avg_l_q   <= '0;
            avg_r_q   <= '0;
            engaged_q <= 1'b0;
            dir_q     <= 1'b0;
            val_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_l_q   <= sum_l_d;
            sum_r_q   <= sum_r_d;
            count_q   <= count_d;
            avg_l_q   <= avg_l_d;
            avg_r_q   <= avg_r_d;
            engaged_q <= engaged_d;
            dir_q     <= dir_d;
            val_q     <= val_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.cmd_valid   = (state_q == StIssue);
    assign bus.dir         = dir_q;
    assign bus.val         = val_q;
    assign bus.sample_drop = drop_q;

endmodule

// File: tb/tb_audio_steer_ctrl.sv
// Randomised self-checking bench for audio_steer_ctrl with a window-level
// reference model of averaging, hysteresis and step saturation.
module tb_audio_steer_ctrl;
    localparam int THRESH     = 8000;
    localparam int HYST       = 1000;
    localparam int STEP_UNIT  = 16;
    localparam int STEP_SHIFT = 5;
    localparam int TIMEOUT    = 100;
    localparam int NPAIR      = 4;
    localparam int VMAX       = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   m_engaged = 0;
    int   last_dir = 0;
    int   last_val = 0;

    audio_steer_ctrl_if #(.W(16), .VAL_W(8)) bus ();

    audio_steer_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // side: 0 = left, 1 = right, 2 = both in the same cycle
    task automatic strobe(input int side, input int l, input int r);
        if (side != 1) begin
            bus.int_l = 16'(l);
            bus.int_l_valid = 1'b1;
        end
        if (side != 0) begin
            bus.int_r = 16'(r);
            bus.int_r_valid = 1'b1;
        end
        tick();
        bus.int_l_valid = 1'b0;
        bus.int_r_valid = 1'b0;
    endtask

    function automatic int clamp16(input int v);
        return (v < 0) ? 0 : ((v > 65535) ? 65535 : v);
    endfunction

    task automatic send_pair(input int l, input int r);
        int mode;
        mode = $urandom_range(0, 3);
        case (mode)
            0: strobe(2, l, r);
            1: begin strobe(0, l, 0); idle($urandom_range(0, 3)); strobe(1, 0, r); end
            2: begin strobe(1, 0, r); idle($urandom_range(0, 3)); strobe(0, l, 0); end
            default: begin
                // a stale left sample is superseded before the partner arrives
                strobe(0, $urandom_range(0, 65535), 0);
                idle($urandom_range(0, 2));
                strobe(0, l, 0);
                idle($urandom_range(0, 2));
                strobe(1, 0, r);
            end
        endcase
    endtask

    task automatic model_decide(input int al, input int ar, output bit cmd,
                                output int dir, output int val);
        int d, ad, thr, steps;
        d   = ar - al;
        ad  = (d < 0) ? -d : d;
        thr = (m_engaged != 0) ? (THRESH - HYST) : THRESH;
        cmd = 1'b0;
        dir = 0;
        val = 0;
        if (ad <= THRESH - HYST) m_engaged = 0;
        if (ad > thr) begin
            steps = STEP_UNIT * ((ad - thr) / (1 << STEP_SHIFT));
            if (steps > VMAX) steps = VMAX;
            if (steps > 0) begin
                cmd = 1'b1;
                dir = (d > 0) ? 1 : 0;
                val = steps;
                m_engaged = 1;
            end
        end
    endtask

    // A lone sample must be dropped exactly TIMEOUT edges after it was latched.
    task automatic timeout_seq();
        strobe($urandom_range(0, 1), $urandom_range(0, 65535), $urandom_range(0, 65535));
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            tick();
            if (i == TIMEOUT - 1) check_eq("err_timeout_early", int'(bus.err_timeout), 0);
            if (i == TIMEOUT)     check_eq("err_timeout_pulse", int'(bus.err_timeout), 1);
            if (i == TIMEOUT + 1) check_eq("err_timeout_end", int'(bus.err_timeout), 0);
        end
    endtask

    task automatic do_reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_engaged = 0;
        last_dir = 0;
        last_val = 0;
    endtask

    task automatic run_window(input int ls[NPAIR], input int rs[NPAIR], input bit do_timeout,
                              input bit do_drop, input int ack_delay, input bit do_rst);
        int al, ar, dir, val;
        bit cmd;
        al = 0;
        ar = 0;
        for (int i = 0; i < NPAIR; i++) begin
            al += ls[i];
            ar += rs[i];
        end
        model_decide(al / NPAIR, ar / NPAIR, cmd, dir, val);
        for (int i = 0; i < NPAIR; i++) begin
            if (i == 2 && do_timeout) timeout_seq();
            if (i > 0) idle($urandom_range(0, 2));
            send_pair(ls[i], rs[i]);
        end
        // window-completing sample was captured on the edge just passed
        check_eq("lat1_cmd_valid", int'(bus.cmd_valid), 0);
        tick();
        check_eq("lat2_cmd_valid", int'(bus.cmd_valid), 0);
        tick();
        check_eq("lat3_cmd_valid", int'(bus.cmd_valid), int'(cmd));
        if (cmd) begin
            check_eq("cmd_dir", int'(bus.dir), dir);
            check_eq("cmd_val", int'(bus.val), val);
            last_dir = dir;
            last_val = val;
            if (do_rst) begin
                do_reset_pulse();
                check_eq("rst_cmd_valid", int'(bus.cmd_valid), 0);
                check_eq("rst_dir", int'(bus.dir), 0);
                check_eq("rst_val", int'(bus.val), 0);
            end else begin
                for (int k = 0; k < ack_delay; k++) begin
                    if (do_drop && k == 0) begin
                        strobe($urandom_range(0, 2), $urandom_range(0, 65535),
                               $urandom_range(0, 65535));
                        check_eq("sample_drop_pulse", int'(bus.sample_drop), 1);
                    end else begin
                        tick();
                        check_eq("sample_drop_idle", int'(bus.sample_drop), 0);
                    end
                    check_eq("hold_cmd_valid", int'(bus.cmd_valid), 1);
                    check_eq("hold_dir", int'(bus.dir), last_dir);
                    check_eq("hold_val", int'(bus.val), last_val);
                end
                bus.motor_ack = 1'b1;
                tick();
                bus.motor_ack = 1'b0;
                check_eq("ack_cmd_valid", int'(bus.cmd_valid), 0);
                check_eq("ack_dir_kept", int'(bus.dir), last_dir);
                check_eq("ack_val_kept", int'(bus.val), last_val);
            end
        end else begin
            tick();
            check_eq("nocmd_cmd_valid", int'(bus.cmd_valid), 0);
            check_eq("nocmd_dir_kept", int'(bus.dir), last_dir);
            check_eq("nocmd_val_kept", int'(bus.val), last_val);
        end
    endtask

    task automatic const_window(input int l, input int r, input bit do_timeout,
                                input bit do_drop, input int ack_delay, input bit do_rst);
        int ls[NPAIR];
        int rs[NPAIR];
        for (int i = 0; i < NPAIR; i++) begin
            ls[i] = l;
            rs[i] = r;
        end
        run_window(ls, rs, do_timeout, do_drop, ack_delay, do_rst);
    endtask

    initial begin
        int ls[NPAIR];
        int rs[NPAIR];
        int base, d;
        bus.int_l = '0;
        bus.int_l_valid = 1'b0;
        bus.int_r = '0;
        bus.int_r_valid = 1'b0;
        bus.motor_ack = 1'b0;
        rst = 1'b1;
        idle(2);
        check_eq("reset_cmd_valid", int'(bus.cmd_valid), 0);
        check_eq("reset_dir", int'(bus.dir), 0);
        check_eq("reset_val", int'(bus.val), 0);
        check_eq("reset_err_timeout", int'(bus.err_timeout), 0);
        check_eq("reset_sample_drop", int'(bus.sample_drop), 0);
        rst = 1'b0;
        tick();

        const_window(1000, 9320, 1'b0, 1'b0, 0, 1'b0);  // dir 1, val 160
        const_window(1000, 8500, 1'b0, 1'b1, 3, 1'b0);  // engaged: val 240
        do_reset_pulse();
        const_window(1000, 8500, 1'b0, 1'b0, 0, 1'b0);  // fresh: no command
        const_window(30000, 0, 1'b1, 1'b0, 1, 1'b0);    // saturated, with timeout
        const_window(1000, 9320, 1'b0, 1'b0, 0, 1'b1);  // reset while issuing
        const_window(1000, 9320, 1'b0, 1'b1, 50, 1'b0); // long ack stall

        for (int w = 0; w < 40; w++) begin
            base = $urandom_range(0, 65535);
            d = int'($urandom_range(0, 30000)) - 15000;
            for (int i = 0; i < NPAIR; i++) begin
                ls[i] = clamp16(base + int'($urandom_range(0, 400)) - 200);
                rs[i] = clamp16(base + d + int'($urandom_range(0, 400)) - 200);
            end
            run_window(ls, rs, ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
                       $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
